// File: rtl/bt_block_buffer.sv
// Block buffer: collects DEPTH words from the pipe-in, then serves them as one block to the pipe-out.
// Optional feature: define BT_BLOCK_BUFFER_CHECKSUM_EN to publish the XOR of each completed block.
module bt_block_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int REVERSE = 0
) (
    input  logic              okClk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_write,
    output logic              in_ready,
    input  logic              out_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ready,
    input  logic              err_clr,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic [15:0]       block_cnt,
    output logic [DATA_W-1:0] checksum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  wr_idx_r;
    logic [IDX_W-1:0]  rd_idx_r;
    logic [IDX_W-1:0]  wr_slot_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              in_ready_r;
    logic              out_ready_r;
    logic [DATA_W-1:0] out_data_r;
    logic              overflow_r;
    logic              underflow_r;
    logic [15:0]       block_cnt_r;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              blk_done_s;
    logic              blk_empty_s;

    assign wr_acc_s    = in_write & in_ready_r;
    assign rd_acc_s    = out_read & out_ready_r;
    assign blk_done_s  = wr_acc_s & (wr_idx_r == IDX_LAST);
    assign blk_empty_s = rd_acc_s & (rd_idx_r == IDX_LAST);
    // With a power-of-two depth, DEPTH-1-idx is simply the bitwise inverse of idx.
    assign wr_slot_s   = (REVERSE != 0) ? ~wr_idx_r : wr_idx_r;

    // Next-state decode for the fill/drain sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY:    if (wr_acc_s)    state_s = FILLING;  else state_s = EMPTY;
            FILLING:  if (blk_done_s)  state_s = FULL;     else state_s = FILLING;
            FULL:     if (rd_acc_s)    state_s = DRAINING; else state_s = FULL;
            DRAINING: if (blk_empty_s) state_s = EMPTY;    else state_s = DRAINING;
            default:  state_s = EMPTY;
        endcase
    end

    // State, indices, handshake flags, readout word and block counter
    always_ff @(posedge okClk) begin
        if (!rstn) begin
            state_r     <= EMPTY;
            wr_idx_r    <= '0;
            rd_idx_r    <= '0;
            in_ready_r  <= 1'b1;
            out_ready_r <= 1'b0;
            out_data_r  <= '0;
            block_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == EMPTY) || (state_s == FILLING);
            out_ready_r <= (state_s == FULL) || (state_s == DRAINING);
            if (wr_acc_s) wr_idx_r <= wr_idx_r + IDX_ONE;
            if (rd_acc_s) begin
                rd_idx_r   <= rd_idx_r + IDX_ONE;
                out_data_r <= mem_r[rd_idx_r];
            end
            if (blk_done_s) block_cnt_r <= block_cnt_r + 16'd1;
        end
    end

    // Block storage; deliberately not reset
    always_ff @(posedge okClk) begin
        if (rstn && wr_acc_s) mem_r[wr_slot_s] <= in_data;
    end

    // Sticky error flags; a new error outranks a clear in the same cycle
    always_ff @(posedge okClk) begin
        if (!rstn) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (in_write && !in_ready_r) overflow_r <= 1'b1;
            else if (err_clr)            overflow_r <= 1'b0;
            else                         overflow_r <= overflow_r;
            if (out_read && !out_ready_r) underflow_r <= 1'b1;
            else if (err_clr)             underflow_r <= 1'b0;
            else                          underflow_r <= underflow_r;
        end
    end

`ifdef BT_BLOCK_BUFFER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] checksum_r;

    // Running XOR of the block being filled, published when the block completes
    always_ff @(posedge okClk) begin
        if (!rstn) begin
            acc_r      <= '0;
            checksum_r <= '0;
        end else if (blk_done_s) begin
            acc_r      <= '0;
            checksum_r <= acc_r ^ in_data;
        end else if (wr_acc_s) begin
            acc_r      <= acc_r ^ in_data;
        end else begin
            acc_r      <= acc_r;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = '0;
`endif

    assign in_ready      = in_ready_r;
    assign out_ready     = out_ready_r;
    assign out_data      = out_data_r;
    assign overflow_err  = overflow_r;
    assign underflow_err = underflow_r;
    assign block_cnt     = block_cnt_r;

endmodule

// File: tb/tb_bt_block_buffer.sv
// Randomised bench for bt_block_buffer: a forward and a reversed instance share stimulus and
// are compared against a block-level reference model every cycle.
module tb_bt_block_buffer;

    localparam int DEPTH = 4;

    logic        okClk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_write = 1'b0;
    logic        out_read = 1'b0;
    logic        err_clr = 1'b0;

    logic        in_ready_f, out_ready_f, ovf_f, udf_f;
    logic [31:0] out_data_f, checksum_f;
    logic [15:0] block_cnt_f;
    logic        in_ready_r, out_ready_r, ovf_r, udf_r;
    logic [31:0] out_data_r, checksum_r;
    logic [15:0] block_cnt_r;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a block is a list of words; readout order is a view over it.
    logic [31:0] m_words [DEPTH];
    int          m_wcnt, m_rcnt;
    bit          m_full, m_ovf, m_udf;
    logic [15:0] m_cnt;
    logic [31:0] m_chk, m_out_f, m_out_r;

    always #5 okClk = ~okClk;

    bt_block_buffer #(.DATA_W(32), .DEPTH(DEPTH), .REVERSE(0)) dut_fwd (
        .okClk(okClk), .rstn(rstn), .in_data(in_data), .in_write(in_write),
        .in_ready(in_ready_f), .out_read(out_read), .out_data(out_data_f),
        .out_ready(out_ready_f), .err_clr(err_clr), .overflow_err(ovf_f),
        .underflow_err(udf_f), .block_cnt(block_cnt_f), .checksum(checksum_f)
    );

    bt_block_buffer #(.DATA_W(32), .DEPTH(DEPTH), .REVERSE(1)) dut_rev (
        .okClk(okClk), .rstn(rstn), .in_data(in_data), .in_write(in_write),
        .in_ready(in_ready_r), .out_read(out_read), .out_data(out_data_r),
        .out_ready(out_ready_r), .err_clr(err_clr), .overflow_err(ovf_r),
        .underflow_err(udf_r), .block_cnt(block_cnt_r), .checksum(checksum_r)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit w, input logic [31:0] d,
                              input bit r, input bit clr);
        bit wa, ra;
        logic [31:0] x;
        if (rst) begin
            m_wcnt = 0; m_rcnt = 0; m_full = 0; m_ovf = 0; m_udf = 0;
            m_cnt = 16'd0; m_chk = 32'd0; m_out_f = 32'd0; m_out_r = 32'd0;
            return;
        end
        wa = w && !m_full;
        ra = r && m_full;
        m_ovf = (w && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = (r && !m_full) ? 1'b1 : (clr ? 1'b0 : m_udf);
        if (ra) begin
            m_out_f = m_words[m_rcnt];
            m_out_r = m_words[DEPTH-1-m_rcnt];
            m_rcnt++;
            if (m_rcnt == DEPTH) begin m_full = 0; m_rcnt = 0; end
        end
        if (wa) begin
            m_words[m_wcnt] = d;
            m_wcnt++;
            if (m_wcnt == DEPTH) begin
                m_full = 1; m_wcnt = 0; m_cnt = m_cnt + 16'd1;
                x = 32'd0;
                for (int i = 0; i < DEPTH; i++) x = x ^ m_words[i];
`ifdef BT_BLOCK_BUFFER_CHECKSUM_EN
                m_chk = x;
`else
                m_chk = 32'd0;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare away from the edge
    task automatic step(input bit rst, input bit w, input logic [31:0] d,
                        input bit r, input bit clr);
        rstn = ~rst; in_write = w; in_data = d; out_read = r; err_clr = clr;
        model_step(rst, w, d, r, clr);
        @(posedge okClk);
        #1;
        check_val("in_ready_f",  {31'd0, in_ready_f},  {31'd0, !m_full});
        check_val("out_ready_f", {31'd0, out_ready_f}, {31'd0, m_full});
        check_val("in_ready_r",  {31'd0, in_ready_r},  {31'd0, !m_full});
        check_val("out_ready_r", {31'd0, out_ready_r}, {31'd0, m_full});
        check_val("out_data_f",  out_data_f, m_out_f);
        check_val("out_data_r",  out_data_r, m_out_r);
        check_val("ovf_f", {31'd0, ovf_f}, {31'd0, m_ovf});
        check_val("udf_f", {31'd0, udf_f}, {31'd0, m_udf});
        check_val("ovf_r", {31'd0, ovf_r}, {31'd0, m_ovf});
        check_val("udf_r", {31'd0, udf_r}, {31'd0, m_udf});
        check_val("block_cnt_f", {16'd0, block_cnt_f}, {16'd0, m_cnt});
        check_val("block_cnt_r", {16'd0, block_cnt_r}, {16'd0, m_cnt});
        check_val("checksum_f", checksum_f, m_chk);
        check_val("checksum_r", checksum_r, m_chk);
    endtask

    initial begin
        logic [31:0] seq [4];
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33; seq[3] = 32'h44;
        model_step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        // Basic block, forward and reversed readout
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq[i], 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);           // overflow, discarded
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);            // clear
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);            // underflow in EMPTY
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);            // error beats clear
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        // Reset in the middle of a block, then a fresh block
        step(1'b0, 1'b1, 32'hAA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hBB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h1 << i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        // Randomised traffic with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
